rand_delay_shell: RTL and testbench
===================================

RAND_DELAY_SHELL -- requirements
Module: rand_delay_shell

Interface
REQ-001 SHALL have parameter TEXT_WIDTH, default 128, width of the plaintext and ciphertext buses.
REQ-002 SHALL have parameter KEY_WIDTH, default 128, width of the key bus.
REQ-003 SHALL have parameter DELAY_BITS, default 6, number of LFSR bits used as a delay count (max delay 2^DELAY_BITS-1).
REQ-004 SHALL have parameter SEED, default 16'hACE1, LFSR reset value and replacement for a zero seed.
REQ-005 SHALL have parameter TIMEOUT_BITS, default 12, width of the core watchdog counter.
REQ-006 SHALL have crypto_clk  in  1  the single clock; every register SHALL be clocked on its rising edge.
REQ-007 SHALL have crypto_rst_n  in  1  synchronous, active-low reset.
REQ-008 SHALL have key_i  in  KEY_WIDTH  key from the register block.
REQ-009 SHALL have text_i  in  TEXT_WIDTH  plaintext from the register block.
REQ-010 SHALL have start_i  in  1  start request from the register block; level or pulse.
REQ-011 SHALL have delay_en_i  in  1  when 1, random delays are enabled; when 0, delays are 0.
REQ-012 SHALL have seed_i  in  16  new LFSR seed.
REQ-013 SHALL have seed_load_i  in  1  seed load strobe.
REQ-014 SHALL have cipher_o  out  TEXT_WIDTH  captured ciphertext.
REQ-015 SHALL have ready_o  out  1  shell can accept start.
REQ-016 SHALL have done_o  out  1  one-cycle completion pulse.
REQ-017 SHALL have idle_o  out  1  FSM is in IDLE.
REQ-018 SHALL have error_o  out  1  sticky watchdog error.
REQ-019 SHALL have trigger_o  out  1  capture trigger, high while the core operation is running.
REQ-020 SHALL have core_key_o, core_text_o  out  KEY_WIDTH/TEXT_WIDTH  latched operands to the core.
REQ-021 SHALL have core_start_o  out  1  one-cycle start pulse to the core.
REQ-022 SHALL have core_cipher_i  in  TEXT_WIDTH  core result.
REQ-023 SHALL have core_done_i  in  1  core result valid; sampled only in WAIT.

Function
REQ-024 LFSR SHALL be a 16-bit Galois LFSR, mask 16'hB400, shifted right every cycle in every state.
REQ-025 When seed_load_i=1 in IDLE, the LFSR SHALL load seed_i, or SEED if seed_i==0; seed_load_i outside IDLE SHALL be ignored.
REQ-026 FSM states SHALL be IDLE, PRE, RUN, WAIT, POST, FIN, in that order.
REQ-027 IDLE->PRE SHALL occur on start_i=1; the shell SHALL latch key_i/text_i into core_key_o/core_text_o and set D1 = delay_en_i ? lfsr[DELAY_BITS-1:0] : 0.
REQ-028 If start_i and seed_load_i are high in the same cycle, both SHALL take effect, and D1 SHALL come from the pre-load LFSR value.
REQ-029 In PRE the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RUN, so core_start_o is high exactly in cycle k+D1+2 when start is sampled at edge k.
REQ-030 RUN SHALL last one cycle with core_start_o=1, then the FSM SHALL go to WAIT and clear the watchdog.
REQ-031 In WAIT, core_done_i=1 SHALL capture core_cipher_i into cipher_o, set D2 from the LFSR (or 0), and go to POST.
REQ-032 In POST the counter SHALL count D2 down to 0, then the FSM SHALL go to FIN; done_o SHALL be high only in the FIN cycle, then the FSM SHALL return to IDLE.
REQ-033 Watchdog: if WAIT lasts 2^TIMEOUT_BITS cycles, the shell SHALL set error_o=1, leave cipher_o unchanged, and go to IDLE with no done_o.
REQ-034 error_o SHALL be cleared only by reset or by the next accepted start.
REQ-035 ready_o and idle_o SHALL be 1 only in IDLE; start_i outside IDLE SHALL be ignored (no queueing).
REQ-036 core_done_i outside WAIT SHALL be ignored.
REQ-037 trigger_o SHALL be 1 from the RUN cycle through the WAIT cycle that captures or times out, inclusive.
REQ-038 cipher_o SHALL hold its value until the next capture.
REQ-039 All outputs SHALL be registered, except ready_o and idle_o, which are decoded from the state register.

Reset
REQ-040 With crypto_rst_n=0 at a clock edge, state SHALL be IDLE, LFSR=SEED, counters=0, cipher_o=0, core_key_o=0, core_text_o=0, core_start_o=0, done_o=0, error_o=0, trigger_o=0.
REQ-041 Reset mid-operation (any state) SHALL abort without a done_o pulse, and ready_o SHALL be 1 in the first cycle after reset release.

Verification
REQ-042 delay_en_i=0, start at edge k, core_done_i 10 cycles after core_start_o, cipher 0x3925841D... -> core_start_o at k+2, done_o 1 cycle after capture+1, cipher_o matches.
REQ-043 seed_load_i with seed_i=0 -> LFSR=16'hACE1; seed_i=16'h0001 -> next value 16'hB400.
REQ-044 delay_en_i=1, seed 16'hACE1, 1000 runs -> core_start_o delay and done delay each equal the model LFSR[5:0], all in 0..63, both ends hit.
REQ-045 start_i held high through the operation and pulsed in WAIT -> exactly one core_start_o per accepted start; second start accepted only after return to IDLE.
REQ-046 core_done_i never asserted -> error_o=1 after 4096 WAIT cycles, no done_o, ready_o=1; the next start clears error_o.
REQ-047 Reset asserted in PRE, WAIT, and POST -> no done_o, outputs at reset values, a clean run afterwards.

Source files
------------

// File: rtl/rand_delay_shell.sv
// Random-delay shell around a crypto core: LFSR-driven pre/post delays,
// operand latching, ciphertext capture, WAIT watchdog and a capture trigger window.
module rand_delay_shell #(
    parameter int          TEXT_WIDTH   = 128,
    parameter int          KEY_WIDTH    = 128,
    parameter int          DELAY_BITS   = 6,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          TIMEOUT_BITS = 12
) (
    input  logic                  crypto_clk,
    input  logic                  crypto_rst_n,
    input  logic [KEY_WIDTH-1:0]  key_i,
    input  logic [TEXT_WIDTH-1:0] text_i,
    input  logic                  start_i,
    input  logic                  delay_en_i,
    input  logic [15:0]           seed_i,
    input  logic                  seed_load_i,
    output logic [TEXT_WIDTH-1:0] cipher_o,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  idle_o,
    output logic                  error_o,
    output logic                  trigger_o,
    output logic [KEY_WIDTH-1:0]  core_key_o,
    output logic [TEXT_WIDTH-1:0] core_text_o,
    output logic                  core_start_o,
    input  logic [TEXT_WIDTH-1:0] core_cipher_i,
    input  logic                  core_done_i
);

    typedef enum logic [2:0] {IDLE, PRE, RUN, WAIT, POST, FIN} state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    state_e                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [DELAY_BITS-1:0]   cnt_q, cnt_d;
    logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;
    logic [TEXT_WIDTH-1:0]   cipher_q, cipher_d;
    logic [KEY_WIDTH-1:0]    key_q, key_d;
    logic [TEXT_WIDTH-1:0]   text_q, text_d;
    logic                    core_start_q, core_start_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    trigger_q, trigger_d;
    logic [DELAY_BITS-1:0]   rand_delay;

    assign rand_delay = delay_en_i ? lfsr_q[DELAY_BITS-1:0] : '0;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        wdog_d   = wdog_q;
        cipher_d = cipher_q;
        key_d    = key_q;
        text_d   = text_q;
        error_d  = error_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

        case (state_q)
            IDLE: begin
                if (seed_load_i) lfsr_d = (seed_i == 16'h0000) ? SEED : seed_i;
                if (start_i) begin
                    state_d = PRE;
                    key_d   = key_i;
                    text_d  = text_i;
                    cnt_d   = rand_delay;
                    error_d = 1'b0;
                end
            end
            PRE: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - DELAY_BITS'(1);
            end
            RUN: begin
                state_d = WAIT;
                wdog_d  = '0;
            end
            WAIT: begin
                // A result arriving on the last watchdog cycle still wins over the timeout.
                if (core_done_i) begin
                    cipher_d = core_cipher_i;
                    cnt_d    = rand_delay;
                    state_d  = POST;
                end else if (wdog_q == '1) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_BITS'(1);
                end
            end
            POST: begin
                if (cnt_q == '0) state_d = FIN;
                else             cnt_d   = cnt_q - DELAY_BITS'(1);
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        core_start_d = (state_d == RUN);
        done_d       = (state_d == FIN);
        trigger_d    = (state_d == RUN) || (state_d == WAIT);
    end

    always_ff @(posedge crypto_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!crypto_rst_n) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            cnt_q        <= '0;
            wdog_q       <= '0;
            cipher_q     <= '0;
            key_q        <= '0;
            text_q       <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            trigger_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            wdog_q       <= wdog_d;
            cipher_q     <= cipher_d;
            key_q        <= key_d;
            text_q       <= text_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            error_q      <= error_d;
            trigger_q    <= trigger_d;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign idle_o       = (state_q == IDLE);
    assign cipher_o     = cipher_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign trigger_o    = trigger_q;
    assign core_key_o   = key_q;
    assign core_text_o  = text_q;
    assign core_start_o = core_start_q;

endmodule

// File: tb/tb_rand_delay_shell.sv
// Bench for rand_delay_shell: directed sequence with randomized operands and core latency,
// timing checked against an LFSR-based delay model held in the bench.
module tb_rand_delay_shell;

    localparam int          TW   = 128;
    localparam int          KW   = 128;
    localparam int          DB   = 6;
    localparam int          TB   = 12;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          crypto_clk = 1'b0;
    logic          crypto_rst_n = 1'b0;
    logic [KW-1:0] key_i = '0;
    logic [TW-1:0] text_i = '0;
    logic          start_i = 1'b0;
    logic          delay_en_i = 1'b0;
    logic [15:0]   seed_i = '0;
    logic          seed_load_i = 1'b0;
    logic [TW-1:0] cipher_o;
    logic          ready_o, done_o, idle_o, error_o, trigger_o;
    logic [KW-1:0] core_key_o;
    logic [TW-1:0] core_text_o;
    logic          core_start_o;
    logic [TW-1:0] core_cipher_i = '0;
    logic          core_done_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int cs_cnt = 0;

    logic [15:0]   m_lfsr = SEED;
    bit            m_idle = 1'b1;
    logic [TW-1:0] m_cipher = '0;

    rand_delay_shell #(
        .TEXT_WIDTH(TW), .KEY_WIDTH(KW), .DELAY_BITS(DB), .SEED(SEED), .TIMEOUT_BITS(TB)
    ) dut (
        .crypto_clk(crypto_clk), .crypto_rst_n(crypto_rst_n),
        .key_i(key_i), .text_i(text_i), .start_i(start_i), .delay_en_i(delay_en_i),
        .seed_i(seed_i), .seed_load_i(seed_load_i),
        .cipher_o(cipher_o), .ready_o(ready_o), .done_o(done_o), .idle_o(idle_o),
        .error_o(error_o), .trigger_o(trigger_o),
        .core_key_o(core_key_o), .core_text_o(core_text_o), .core_start_o(core_start_o),
        .core_cipher_i(core_cipher_i), .core_done_i(core_done_i)
    );

    always #5 crypto_clk = ~crypto_clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [TW-1:0] rnd_text();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: the LFSR free-runs every cycle; a seed load only lands while the shell is idle.
    always @(posedge crypto_clk) begin
        cyc <= cyc + 1;
        if (done_o) done_cnt <= done_cnt + 1;
        if (core_start_o) cs_cnt <= cs_cnt + 1;
        if (!crypto_rst_n)               m_lfsr <= SEED;
        else if (m_idle && seed_load_i)  m_lfsr <= (seed_i == 16'h0) ? SEED : seed_i;
        else                             m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge crypto_clk);
        @(negedge crypto_clk);
    endtask

    task automatic accept(input bit den, input bit seed_ld, input logic [15:0] seed,
                          output int k, output int d1);
        logic [KW-1:0] key;
        logic [TW-1:0] txt;
        key = rnd_text();
        txt = rnd_text();
        check("ready_before_start", ready_o, 1);
        key_i = key; text_i = txt; delay_en_i = den;
        start_i = 1'b1; seed_load_i = seed_ld; seed_i = seed;
        d1 = den ? int'(m_lfsr[DB-1:0]) : 0;
        tick();
        k = cyc; m_idle = 1'b0; start_i = 1'b0; seed_load_i = 1'b0;
        check("core_key_latched", core_key_o, key);
        check("core_text_latched", core_text_o, txt);
        check("busy_after_start", {ready_o, idle_o}, 2'b00);
        check("error_clear_on_start", error_o, 0);
    endtask

    task automatic wait_core_start(input int k, input int d1, output int r);
        int n;
        n = 0;
        while (core_start_o !== 1'b1 && n < 200) begin
            core_done_i   = 1'($urandom_range(0, 1));
            core_cipher_i = rnd_text();
            seed_load_i   = 1'($urandom_range(0, 1));
            seed_i        = 16'($urandom());
            tick();
            n++;
        end
        core_done_i = 1'b0; seed_load_i = 1'b0;
        r = cyc;
        check("core_start_delay", r - k, d1 + 1);
        check("trigger_in_run", trigger_o, 1);
        check("cipher_hold_pre", cipher_o, m_cipher);
    endtask

    task automatic respond(input bit den, input int lat, input logic [TW-1:0] ct,
                           output int c, output int d2);
        repeat (lat) begin
            seed_load_i = 1'($urandom_range(0, 1));
            seed_i      = 16'($urandom());
            tick();
            check("trigger_in_wait", trigger_o, 1);
        end
        seed_load_i = 1'b0;
        core_done_i = 1'b1; core_cipher_i = ct;
        d2 = den ? int'(m_lfsr[DB-1:0]) : 0;
        tick();
        c = cyc; core_done_i = 1'b0; core_cipher_i = rnd_text(); m_cipher = ct;
        check("cipher_capture", cipher_o, ct);
        check("trigger_after_capture", trigger_o, 0);
    endtask

    task automatic wait_done(input int c, input int d2, input int cs0);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 200) begin
            core_done_i   = 1'($urandom_range(0, 1));
            core_cipher_i = rnd_text();
            tick();
            n++;
        end
        core_done_i = 1'b0;
        check("done_delay", cyc - c, d2 + 1);
        check("cipher_hold_post", cipher_o, m_cipher);
        check("one_core_start", cs_cnt - cs0, 1);
        tick();
        m_idle = 1'b1;
        check("done_one_cycle", done_o, 0);
        check("ready_after_fin", {ready_o, idle_o}, 2'b11);
    endtask

    task automatic run_op(input bit den, input int lat, input logic [TW-1:0] ct,
                          output int d1, output int d2);
        int k, r, c, cs0;
        cs0 = cs_cnt;
        accept(den, 1'b0, 16'h0, k, d1);
        wait_core_start(k, d1, r);
        respond(den, lat, ct, c, d2);
        wait_done(c, d2, cs0);
    endtask

    task automatic reset_check(input string where);
        int dc0;
        dc0 = done_cnt;
        crypto_rst_n = 1'b0; start_i = 1'b0; core_done_i = 1'b0; seed_load_i = 1'b0;
        m_idle = 1'b1; m_cipher = '0;
        tick(); tick();
        check({where, "_rst_cipher"}, cipher_o, 0);
        check({where, "_rst_key"}, core_key_o, 0);
        check({where, "_rst_text"}, core_text_o, 0);
        check({where, "_rst_flags"}, {core_start_o, done_o, error_o, trigger_o}, 4'b0000);
        crypto_rst_n = 1'b1;
        tick();
        check({where, "_ready_after_release"}, ready_o, 1);
        tick();
        check({where, "_no_done"}, done_cnt - dc0, 0);
    endtask

    initial begin
        int d1, d2, k, r, c, cs0, dc0, n;
        bit h1lo, h1hi, h2lo, h2hi;
        h1lo = 0; h1hi = 0; h2lo = 0; h2hi = 0;

        reset_check("init");

        // Delays disabled, fixed ciphertext, core answers 10 cycles after its start pulse.
        run_op(1'b0, 10, 128'h3925841d02dc09fbdc118597196a0b32, d1, d2);

        for (int i = 0; i < 1000 && !(h1lo && h1hi && h2lo && h2hi); i++) begin
            run_op(1'b1, $urandom_range(1, 3), rnd_text(), d1, d2);
            if (d1 == 0) h1lo = 1;
            if (d1 == 63) h1hi = 1;
            if (d2 == 0) h2lo = 1;
            if (d2 == 63) h2hi = 1;
        end
        check("pre_delay_hits_0_and_63", {h1lo, h1hi}, 2'b11);
        check("post_delay_hits_0_and_63", {h2lo, h2hi}, 2'b11);

        // Zero seed loads the default seed: first delay is ACE1[5:0] = 33.
        seed_load_i = 1'b1; seed_i = 16'h0000;
        tick();
        seed_load_i = 1'b0;
        cs0 = cs_cnt;
        accept(1'b1, 1'b0, 16'h0, k, d1);
        wait_core_start(k, 33, r);
        respond(1'b1, 2, rnd_text(), c, d2);
        wait_done(c, d2, cs0);

        // Seed 0001 steps to B400, so a start one cycle later sees delay 0.
        seed_load_i = 1'b1; seed_i = 16'h0001;
        tick();
        seed_load_i = 1'b0;
        tick();
        cs0 = cs_cnt;
        accept(1'b1, 1'b0, 16'h0, k, d1);
        wait_core_start(k, 0, r);
        respond(1'b1, 1, rnd_text(), c, d2);
        wait_done(c, d2, cs0);

        // Start and seed load together: pre-delay from the old LFSR, post-delay from the new seed.
        cs0 = cs_cnt;
        accept(1'b1, 1'b1, 16'h1234, k, d1);
        wait_core_start(k, d1, r);
        respond(1'b1, 3, rnd_text(), c, d2);
        wait_done(c, d2, cs0);

        // start_i held high throughout: one core start, re-accepted only back in IDLE.
        cs0 = cs_cnt;
        accept(1'b0, 1'b0, 16'h0, k, d1);
        start_i = 1'b1;
        wait_core_start(k, 0, r);
        respond(1'b0, 4, rnd_text(), c, d2);
        wait_done(c, 0, cs0);
        cs0 = cs_cnt;
        tick();
        k = cyc; m_idle = 1'b0; start_i = 1'b0;
        check("held_start_reaccepted", ready_o, 0);
        wait_core_start(k, 0, r);
        respond(1'b0, 2, rnd_text(), c, d2);
        wait_done(c, 0, cs0);

        // Watchdog: the core never answers.
        dc0 = done_cnt;
        accept(1'b0, 1'b0, 16'h0, k, d1);
        wait_core_start(k, 0, r);
        n = 0;
        while (error_o !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        m_idle = 1'b1;
        check("timeout_cycle", cyc - r, 4097);
        check("timeout_ready", ready_o, 1);
        check("timeout_trigger_low", trigger_o, 0);
        check("timeout_cipher_unchanged", cipher_o, m_cipher);
        repeat (3) tick();
        check("error_sticky", error_o, 1);
        check("timeout_no_done", done_cnt - dc0, 0);
        run_op(1'b1, 2, rnd_text(), d1, d2);

        // Reset in PRE, WAIT and POST, each followed by a clean run.
        accept(1'b1, 1'b0, 16'h0, k, d1);
        reset_check("pre");
        run_op(1'b1, 2, rnd_text(), d1, d2);

        accept(1'b0, 1'b0, 16'h0, k, d1);
        wait_core_start(k, 0, r);
        tick();
        reset_check("wait");
        run_op(1'b1, 1, rnd_text(), d1, d2);

        accept(1'b0, 1'b0, 16'h0, k, d1);
        wait_core_start(k, 0, r);
        respond(1'b1, 1, rnd_text(), c, d2);
        reset_check("post");
        run_op(1'b1, 3, rnd_text(), d1, d2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
